// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback types: write-back select, load funct3 codes, stage entry.
package rv32i_pkg;

   localparam int unsigned RV_XLEN = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned F3_W    = 3;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10,
      WB_ILL = 2'b11
   } wbsel_e;

   localparam logic [F3_W-1:0] F3_LB  = 3'b000;
   localparam logic [F3_W-1:0] F3_LH  = 3'b001;
   localparam logic [F3_W-1:0] F3_LW  = 3'b010;
   localparam logic [F3_W-1:0] F3_LBU = 3'b100;
   localparam logic [F3_W-1:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [RV_XLEN-1:0] pc;
      logic [RV_XLEN-1:0] alu_res;
      logic [RV_XLEN-1:0] memrdata;
      logic [F3_W-1:0]    funct3;
      wbsel_e             wbsel;
      logic               regwren;
      logic [REG_W-1:0]   rd;
   } wb_entry_t;

   // Link address; wraps modulo 2^XLEN.
   function automatic logic [RV_XLEN-1:0] wb_pc4(input logic [RV_XLEN-1:0] pc);
      return pc + RV_XLEN'(4);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from an aligned load word and extends it.
module load_extend
   import rv32i_pkg::*;
(
   input  logic [F3_W-1:0]    funct3,
   input  logic [1:0]         offset,
   input  logic [RV_XLEN-1:0] word,
   output logic [RV_XLEN-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then sign/zero extension; unknown funct3 returns the whole word.
   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[RV_XLEN-1 -: 16] : word[15:0];
      data_c   = word;
      case (funct3)
         F3_LB:   data_c = {{(RV_XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data_c = {{(RV_XLEN-8){1'b0}}, byte_sel};
         F3_LH:   data_c = {{(RV_XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  data_c = {{(RV_XLEN-16){1'b0}}, half_sel};
         F3_LW:   data_c = word;
         default: data_c = word;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: two-entry elastic buffer feeding the register-file write port.
module writeback_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned     XLEN          = RV_XLEN,
   parameter int unsigned     CNT_W         = 64,
   parameter logic [CNT_W-1:0] RESET_INSTRET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  alu_res_i,
   input  logic [XLEN-1:0]  memrdata_i,
   input  logic [2:0]       funct3_i,
   input  logic [1:0]       wbsel_i,
   input  logic             regwren_i,
   input  logic [4:0]       rd_i,
   input  logic             wb_stall_i,
   output logic [4:0]       rd_o,
   output logic [XLEN-1:0]  datawb_o,
   output logic             regwren_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] instret_o
);

   wb_entry_t        main_q, main_d;
   wb_entry_t        skid_q, skid_d;
   wb_entry_t        in_entry;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             in_fire;
   logic             out_fire;
   logic [XLEN-1:0]  load_data;

   // Pack the incoming instruction into a buffer entry.
   always_comb begin
      in_entry.pc       = pc_i;
      in_entry.alu_res  = alu_res_i;
      in_entry.memrdata = memrdata_i;
      in_entry.funct3   = funct3_i;
      in_entry.wbsel    = wbsel_e'(wbsel_i);
      in_entry.regwren  = regwren_i;
      in_entry.rd       = rd_i;
   end

   assign ready_o  = ~skid_valid_q;
   assign in_fire  = valid_i & ready_o;
   assign out_fire = main_valid_q & ~wb_stall_i;

   // Buffer advance: skid refills main first; a stalled main diverts input into the skid.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      instret_d    = instret_q;
      if (!main_valid_q || out_fire) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      if (out_fire) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   // State registers; reset discards any buffered entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         instret_q    <= RESET_INSTRET;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         instret_q    <= instret_d;
      end
   end

   load_extend u_load_extend (
      .funct3 (main_q.funct3),
      .offset (main_q.alu_res[1:0]),
      .word   (main_q.memrdata),
      .data_c (load_data)
   );

   // Write-port drive from the main entry; illegal select and x0 never write.
   always_comb begin
      rd_o      = '0;
      datawb_o  = '0;
      regwren_o = 1'b0;
      retire_o  = out_fire;
      if (main_valid_q) begin
         rd_o = main_q.rd;
         case (main_q.wbsel)
            WB_ALU:  datawb_o = main_q.alu_res;
            WB_MEM:  datawb_o = load_data;
            WB_PC4:  datawb_o = wb_pc4(main_q.pc);
            default: datawb_o = '0;
         endcase
         regwren_o = out_fire & main_q.regwren & (main_q.rd != '0) & (main_q.wbsel != WB_ILL);
      end
   end

   assign instret_o = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage.
module tb_writeback_stage;

   localparam logic [63:0] RST_CNT = 64'hFFFF_FFFF_FFFF_FFE0;

   logic        clk, rst;
   logic        valid_i, ready_o;
   logic [31:0] pc_i, alu_res_i, memrdata_i;
   logic [2:0]  funct3_i;
   logic [1:0]  wbsel_i;
   logic        regwren_i;
   logic [4:0]  rd_i;
   logic        wb_stall_i;
   logic [4:0]  rd_o;
   logic [31:0] datawb_o;
   logic        regwren_o, retire_o;
   logic [63:0] instret_o;

   writeback_stage #(.XLEN(32), .CNT_W(64), .RESET_INSTRET(RST_CNT)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
      .pc_i(pc_i), .alu_res_i(alu_res_i), .memrdata_i(memrdata_i),
      .funct3_i(funct3_i), .wbsel_i(wbsel_i), .regwren_i(regwren_i), .rd_i(rd_i),
      .wb_stall_i(wb_stall_i), .rd_o(rd_o), .datawb_o(datawb_o),
      .regwren_o(regwren_o), .retire_o(retire_o), .instret_o(instret_o)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        wren;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          occ      = 0;
   logic [63:0] exp_instret = RST_CNT;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference write-back value, straight from the select/load rules.
   function automatic logic [31:0] exp_data(input logic [31:0] pc, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [2:0] f3,
                                            input logic [1:0] ws);
      int unsigned off;
      logic [31:0] b, h;
      off = alu % 4;
      b = (mem >> (8 * off)) & 32'hFF;
      h = (mem >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      case (ws)
         2'd0: return alu;
         2'd2: return pc + 32'd4;
         2'd3: return 32'd0;
         default: begin
            case (f3)
               3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
               3'd4:    return b;
               3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
               3'd5:    return h;
               default: return mem;
            endcase
         end
      endcase
   endfunction

   // One clock of stimulus; occupancy model predicts ready/retire and scores accepted entries.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [2:0] f3, input logic [1:0] ws,
                        input logic wr, input logic [4:0] rd, input logic st);
      logic exp_ready, in_f, out_f;
      @(posedge clk);
      #1;
      valid_i = v; pc_i = pc; alu_res_i = alu; memrdata_i = mem; funct3_i = f3;
      wbsel_i = ws; regwren_i = wr; rd_i = rd; wb_stall_i = st;
      #3;
      exp_ready = (occ < 2);
      out_f     = (occ > 0) && !st;
      check("ready_o", 64'(ready_o), 64'(exp_ready));
      check("retire_o", 64'(retire_o), 64'(out_f));
      in_f = v && exp_ready;
      if (in_f) sb.push_back('{rd, exp_data(pc, alu, mem, f3, ws), wr && (rd != 5'd0) && (ws != 2'd3)});
      occ = occ + int'(in_f) - int'(out_f);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Monitor: pops the scoreboard on each retirement and tracks the instret count.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_instret = RST_CNT;
         end else begin
            check("instret_o", instret_o, exp_instret);
            if (retire_o) begin
               if (sb.size() == 0) begin
                  check("retire_without_entry", 64'(1), 64'(0));
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("rd_o", 64'(rd_o), 64'(e.rd));
                  check("datawb_o", 64'(datawb_o), 64'(e.data));
                  check("regwren_o", 64'(regwren_o), 64'(e.wren));
               end
               exp_instret = exp_instret + 64'd1;
            end else begin
               check("regwren_o_idle", 64'(regwren_o), 64'(0));
            end
         end
      end
   end

   localparam logic [31:0] MW = 32'h80F0_7F81;

   initial begin
      rst = 1'b1; valid_i = 0; pc_i = 0; alu_res_i = 0; memrdata_i = 0;
      funct3_i = 0; wbsel_i = 0; regwren_i = 0; rd_i = 0; wb_stall_i = 0;
      #3;
      check("rst_ready_o", 64'(ready_o), 64'(1));
      check("rst_instret_o", instret_o, RST_CNT);
      check("rst_retire_o", 64'(retire_o), 64'(0));
      @(posedge clk); #2; rst = 1'b0;

      // ALU write, loads, PC+4 wrap, non-writing retirements
      cycle(1, 32'h100, 32'd123, 0, 3'd0, 2'd0, 1, 5'd5, 0);
      cycle(1, 0, 32'h1000, MW, 3'd0, 2'd1, 1, 5'd1, 0);
      cycle(1, 0, 32'h1003, MW, 3'd4, 2'd1, 1, 5'd2, 0);
      cycle(1, 0, 32'h1002, MW, 3'd1, 2'd1, 1, 5'd3, 0);
      cycle(1, 0, 32'h1000, MW, 3'd5, 2'd1, 1, 5'd4, 0);
      cycle(1, 0, 32'h1001, MW, 3'd2, 2'd1, 1, 5'd6, 0);
      cycle(1, 32'hFFFF_FFFC, 0, 0, 3'd0, 2'd2, 1, 5'd7, 0);
      cycle(1, 0, 32'd55, 0, 3'd0, 2'd0, 1, 5'd0, 0);
      cycle(1, 0, 32'd66, 0, 3'd0, 2'd3, 1, 5'd9, 0);
      idle(3);

      // Stall for three cycles while two instructions are offered; third is refused
      cycle(1, 0, 32'd11, 0, 3'd0, 2'd0, 1, 5'd10, 1);
      cycle(1, 0, 32'd22, 0, 3'd0, 2'd0, 1, 5'd11, 1);
      cycle(1, 0, 32'd33, 0, 3'd0, 2'd0, 1, 5'd12, 1);
      idle(3);

      // Reset with main and skid both occupied
      cycle(1, 0, 32'd44, 0, 3'd0, 2'd0, 1, 5'd13, 1);
      cycle(1, 0, 32'd77, 0, 3'd0, 2'd0, 1, 5'd14, 1);
      @(posedge clk); #2;
      valid_i = 0; wb_stall_i = 0; rst = 1'b1;
      #1;
      check("rst_mid_rd_o", 64'(rd_o), 64'(0));
      check("rst_mid_datawb_o", 64'(datawb_o), 64'(0));
      check("rst_mid_regwren_o", 64'(regwren_o), 64'(0));
      check("rst_mid_retire_o", 64'(retire_o), 64'(0));
      check("rst_mid_ready_o", 64'(ready_o), 64'(1));
      check("rst_mid_instret_o", instret_o, RST_CNT);
      sb.delete();
      occ = 0;
      @(posedge clk); #2; rst = 1'b0;
      idle(2);

      // Random traffic; instret wraps through zero along the way
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 4) != 0, $urandom, $urandom, $urandom, 3'($urandom % 8),
               2'($urandom % 4), 1'($urandom % 2), 5'($urandom % 32), ($urandom % 4) == 0);
      end
      idle(4);
      check("scoreboard_drained", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
